// File: rtl/parking_gate_arbiter.sv
// ---------------------------------------------------------------------------
// parking_gate_arbiter
//
// Purpose:
//   Shares the lot's single barrier lane and occupancy counter between the
//   entry and exit gate FSMs. At most one barrier is open at a time. When
//   both gates contend, they are served round-robin. Entry is blocked when
//   the lot is full and exit is blocked when it is empty. This block holds
//   the authoritative occupancy count.
//
// Ports:
//   clk         in   1      system clock, rising edge
//   reset       in   1      asynchronous active-high reset
//   entry_req   in   1      level: a vehicle is waiting at the entry gate
//   exit_req    in   1      level: a vehicle is waiting at the exit gate
//   entry_pass  in   1      1-cycle pulse: a vehicle cleared the entry barrier
//   exit_pass   in   1      1-cycle pulse: a vehicle cleared the exit barrier
//   entry_open  out  1      registered: entry barrier open
//   exit_open   out  1      registered: exit barrier open
//   count       out  CNT_W  registered occupancy
//   full        out  1      count == CAPACITY
//   empty       out  1      count == 0
//   abort       out  1      registered 1-cycle pulse when a barrier times out
//
// Optional feature (macro PARK_STATS_EN):
//   in_total[15:0]    wrapping count of counted entry passes
//   out_total[15:0]   wrapping count of counted exit passes
//   abort_total[7:0]  count of abort pulses, saturating at 255
// ---------------------------------------------------------------------------
module parking_gate_arbiter #(
    parameter int unsigned CAPACITY = 15,
    parameter int unsigned CNT_W    = 4,
    parameter int unsigned TIMEOUT  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             entry_req,
    input  logic             exit_req,
    input  logic             entry_pass,
    input  logic             exit_pass,
    output logic             entry_open,
    output logic             exit_open,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             abort
`ifdef PARK_STATS_EN
    ,
    output logic [15:0]      in_total,
    output logic [15:0]      out_total,
    output logic [7:0]       abort_total
`endif
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, OPEN_IN, OPEN_OUT} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               last_in_q, last_in_d;   // 1: last grant was entry
    logic               abort_q, abort_d;
    logic               entry_open_q, exit_open_q;
    logic               elig_in, elig_out;

    assign full    = (count_q == CNT_W'(CAPACITY));
    assign empty   = (count_q == '0);
    assign elig_in  = entry_req & ~full;
    assign elig_out = exit_req & ~empty;

    assign entry_open = entry_open_q;
    assign exit_open  = exit_open_q;
    assign count      = count_q;
    assign abort      = abort_q;

`ifdef PARK_STATS_EN
    logic inc_evt, dec_evt;
`endif

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        timer_d   = timer_q;
        last_in_d = last_in_q;
        abort_d   = 1'b0;
`ifdef PARK_STATS_EN
        inc_evt   = 1'b0;
        dec_evt   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                timer_d = '0;
                // On a tie, grant the side opposite to the previous grant.
                if (elig_in && (!elig_out || !last_in_q)) begin
                    state_d = OPEN_IN;
                end else if (elig_out) begin
                    state_d = OPEN_OUT;
                end
            end
            OPEN_IN: begin
                timer_d = timer_q + TMR_W'(1);
                if (entry_pass) begin
                    if (count_q != CNT_W'(CAPACITY)) begin
                        count_d = count_q + CNT_W'(1);
`ifdef PARK_STATS_EN
                        inc_evt = 1'b1;
`endif
                    end
                    last_in_d = 1'b1;
                    timer_d   = '0;
                    state_d   = IDLE;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    abort_d   = 1'b1;
                    last_in_d = 1'b1;
                    timer_d   = '0;
                    state_d   = IDLE;
                end
            end
            OPEN_OUT: begin
                timer_d = timer_q + TMR_W'(1);
                if (exit_pass) begin
                    if (count_q != '0) begin
                        count_d = count_q - CNT_W'(1);
`ifdef PARK_STATS_EN
                        dec_evt = 1'b1;
`endif
                    end
                    last_in_d = 1'b0;
                    timer_d   = '0;
                    state_d   = IDLE;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    abort_d   = 1'b1;
                    last_in_d = 1'b0;
                    timer_d   = '0;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            count_q      <= '0;
            timer_q      <= '0;
            last_in_q    <= 1'b0;
            abort_q      <= 1'b0;
            entry_open_q <= 1'b0;
            exit_open_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            timer_q      <= timer_d;
            last_in_q    <= last_in_d;
            abort_q      <= abort_d;
            // Open flags mirror the next state so they leave the flop directly.
            entry_open_q <= (state_d == OPEN_IN);
            exit_open_q  <= (state_d == OPEN_OUT);
        end
    end

`ifdef PARK_STATS_EN
    logic [15:0] in_total_q, in_total_d, out_total_q, out_total_d;
    logic [7:0]  abort_total_q, abort_total_d;

    always_comb begin
        in_total_d    = in_total_q + (inc_evt ? 16'd1 : 16'd0);
        out_total_d   = out_total_q + (dec_evt ? 16'd1 : 16'd0);
        abort_total_d = abort_total_q;
        if (abort_d && abort_total_q != '1) begin
            abort_total_d = abort_total_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_total_q    <= '0;
            out_total_q   <= '0;
            abort_total_q <= '0;
        end else begin
            in_total_q    <= in_total_d;
            out_total_q   <= out_total_d;
            abort_total_q <= abort_total_d;
        end
    end

    assign in_total    = in_total_q;
    assign out_total   = out_total_q;
    assign abort_total = abort_total_q;
`endif

endmodule
